// File: rtl/shift_pkg.sv
// Shared constants for the universal shift register: MODE encodings.
package shift_pkg;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

endpackage : shift_pkg

// File: rtl/shift_reg_univ_dff_ar.sv
// Single bit cell: rising-edge D flip-flop with enable and async active-low reset to RST_VAL.
module dff_ar #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : dff_ar

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift right / shift left / parallel load, with optional
// rotate, a saturating count of serial bits shifted in, and a one-cycle word-complete pulse.
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         EN,
  input  logic                         CLR,
  input  logic [1:0]                   MODE,
  input  logic                         ROT,
  input  logic                         SIN_MSB,
  input  logic                         SIN_LSB,
  input  logic [WIDTH-1:0]             D,
  output logic [WIDTH-1:0]             Q,
  output logic                         SOUT_MSB,
  output logic                         SOUT_LSB,
  output logic [$clog2(WIDTH+1)-1:0]   CNT,
  output logic                         READY
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_d_next;
  logic             w_cell_en;
  logic             w_serial;
  logic [CW-1:0]    r_cnt;
  logic             r_ready;

  // Next-state bit mux; CLR overrides everything, EN gating is applied via the cell enable.
  always_comb begin
    w_d_next = w_q;
    unique case (MODE)
      SHR:     w_d_next = {(ROT ? w_q[0] : SIN_MSB), w_q[WIDTH-1:1]};
      SHL:     w_d_next = {w_q[WIDTH-2:0], (ROT ? w_q[WIDTH-1] : SIN_LSB)};
      LOAD:    w_d_next = D;
      default: w_d_next = w_q;
    endcase
    if (CLR) begin
      w_d_next = '0;
    end
  end

  assign w_cell_en = CLR | (EN & (MODE != HOLD));
  assign w_serial  = EN & ~ROT & ((MODE == SHR) | (MODE == SHL));

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    dff_ar #(
      .RST_VAL (RESET_VAL[i])
    ) u_cell (
      .clk   (CLK),
      .rst_n (RST_N),
      .en    (w_cell_en),
      .d     (w_d_next[i]),
      .q     (w_q[i])
    );
  end

  // READY fires only on the WIDTH-1 -> WIDTH transition, never again while saturated.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (CLR) begin
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (EN && (MODE == LOAD)) begin
        r_cnt <= '0;
      end else if (w_serial && (r_cnt != CNT_MAX)) begin
        r_cnt   <= r_cnt + CW'(1);
        r_ready <= (r_cnt == CNT_LAST);
      end
    end
  end

  assign Q        = w_q;
  assign SOUT_MSB = w_q[WIDTH-1];
  assign SOUT_LSB = w_q[0];
  assign CNT      = r_cnt;
  assign READY    = r_ready;

endmodule : shift_reg_univ
